frame_color_stats: RTL and testbench

- Per-frame colour statistics unit on the camera write stream; a downstream consumer of the capture stage's pixel/address/write-strobe outputs, tapped in parallel with the frame-buffer write port.
- On a start request it arms, waits for the next frame start, classifies every written RGB332 pixel as red, green, blue or other, and counts each class.
- At frame end it reports the counts and a dominant-colour code for the project's colour-detection logic.

---
 rtl/frame_color_stats_if.sv | 27 ++
 rtl/frame_color_stats.sv | 147 ++++++++++++++
 tb/tb_frame_color_stats.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/frame_color_stats_if.sv
// Pixel tap, measurement request and result bundle for frame_color_stats.
// master drives the capture-side stream and start; slave is the statistics unit.
interface frame_color_stats_if #(
    parameter int unsigned AW = 17
) ();
    logic          vsync;
    logic          px_valid;
    logic [AW-1:0] px_addr;
    logic [7:0]    px_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [1:0]    color;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_g;
    logic [AW-1:0] cnt_b;

    modport master (
        output vsync, px_valid, px_addr, px_data, start,
        input  busy, done, color, cnt_r, cnt_g, cnt_b
    );

    modport slave (
        input  vsync, px_valid, px_addr, px_data, start,
        output busy, done, color, cnt_r, cnt_g, cnt_b
    );
endinterface

// File: rtl/frame_color_stats.sv
// Per-frame colour statistics: counts red/green/blue RGB332 pixels written during one
// frame and reports the counts plus a dominant-colour code when the frame ends.
module frame_color_stats #(
    parameter int unsigned AW        = 17,
    parameter int unsigned NPIX      = 76800,
    parameter int unsigned TH        = 5,
    parameter int unsigned TL        = 3,
    parameter int unsigned MIN_COUNT = 1024
) (
    input logic                 clk,
    input logic                 rst,
    frame_color_stats_if.slave  bus
);
    localparam logic [2:0]    TH3      = 3'(TH);
    localparam logic [2:0]    TL3      = 3'(TL);
    localparam logic [AW-1:0] LAST     = AW'(NPIX - 1);
    localparam logic [AW-1:0] MIN_CNT  = AW'(MIN_COUNT);
    localparam logic [AW-1:0] ONE      = AW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StAccum,
        StDecide
    } state_e;

    state_e        state_q, state_d;
    logic          vsync_q;
    logic          clear, inc;
    logic [AW-1:0] acc_r, acc_g, acc_b;
    logic [AW-1:0] cnt_r_q, cnt_g_q, cnt_b_q;
    logic [1:0]    color_q, color_d;
    logic          done_q;
    logic [2:0]    ch_r, ch_g, ch_b;
    logic          is_red, is_green, is_blue;
    logic [1:0]    win_code;
    logic [AW-1:0] win_cnt;
    logic          frame_start, frame_end;

    assign frame_start = vsync_q & ~bus.vsync;
    assign frame_end   = ~vsync_q & bus.vsync;

    // Classify the incoming pixel; blue is widened to 3 bits by repeating its MSB.
    always_comb begin
        ch_r     = bus.px_data[7:5];
        ch_g     = bus.px_data[4:2];
        ch_b     = {bus.px_data[1:0], bus.px_data[1]};
        is_red   = (ch_r >= TH3) && (ch_g < TL3) && (ch_b < TL3);
        is_green = (ch_g >= TH3) && (ch_r < TL3) && (ch_b < TL3);
        is_blue  = (ch_b >= TH3) && (ch_r < TL3) && (ch_g < TL3);
    end

    // State register and VSYNC edge-detect delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            vsync_q <= 1'b1;
        end else begin
            state_q <= state_d;
            vsync_q <= bus.vsync;
        end
    end

    // Next-state logic; a last-address pixel coinciding with frame end is one transition.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        inc     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StArm;
            end
            StArm: begin
                if (frame_start) begin
                    clear   = 1'b1;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                inc = bus.px_valid;
                if ((bus.px_valid && bus.px_addr == LAST) || frame_end) state_d = StDecide;
            end
            StDecide: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Saturating per-class accumulators, cleared at the frame start that follows arming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else if (clear) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else if (inc) begin
            if (is_red   && acc_r != '1) acc_r <= acc_r + ONE;
            if (is_green && acc_g != '1) acc_g <= acc_g + ONE;
            if (is_blue  && acc_b != '1) acc_b <= acc_b + ONE;
        end
    end

    // Strictly-largest winner; ties fall to red, then green, then blue.
    always_comb begin
        if (acc_r >= acc_g && acc_r >= acc_b) begin
            win_code = 2'b01;
            win_cnt  = acc_r;
        end else if (acc_g >= acc_b) begin
            win_code = 2'b10;
            win_cnt  = acc_g;
        end else begin
            win_code = 2'b11;
            win_cnt  = acc_b;
        end
        color_d = (win_cnt >= MIN_CNT) ? win_code : 2'b00;
    end

    // Result registers update leaving DECIDE, together with the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r_q <= '0;
            cnt_g_q <= '0;
            cnt_b_q <= '0;
            color_q <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == StDecide);
            if (state_q == StDecide) begin
                cnt_r_q <= acc_r;
                cnt_g_q <= acc_g;
                cnt_b_q <= acc_b;
                color_q <= color_d;
            end
        end
    end

    assign bus.busy  = (state_q != StIdle);
    assign bus.done  = done_q;
    assign bus.color = color_q;
    assign bus.cnt_r = cnt_r_q;
    assign bus.cnt_g = cnt_g_q;
    assign bus.cnt_b = cnt_b_q;
endmodule

// File: tb/tb_frame_color_stats.sv
// Directed bench for frame_color_stats with a 16-pixel frame and MIN_COUNT of 4.
module tb_frame_color_stats;
    localparam int unsigned AW = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   addr    = 0;

    frame_color_stats_if #(.AW(AW)) bus ();

    frame_color_stats #(
        .AW(AW),
        .NPIX(16),
        .TH(5),
        .TL(3),
        .MIN_COUNT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start from IDLE; the unit must then sit in ARM.
    task automatic arm();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("arm_busy", 32'(bus.busy), 32'd1);
    endtask

    // Drop VSYNC to open the frame and restart the address sequence.
    task automatic fstart();
        bus.vsync = 1'b0;
        tick();
        addr = 0;
    endtask

    task automatic pix(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bus.px_valid = 1'b1;
            bus.px_addr  = AW'(addr);
            bus.px_data  = d;
            tick();
            addr++;
        end
        bus.px_valid = 1'b0;
    endtask

    // Called one cycle after the ACCUM->DECIDE edge; done must appear on the next cycle.
    task automatic expect_result(input string tag, input int r, input int g, input int b,
                                 input int c, input bit start_in_decide);
        chk({tag, "_early_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_decide_busy"}, 32'(bus.busy), 32'd1);
        bus.start = start_in_decide;
        tick();
        bus.start = 1'b0;
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_cnt_r"}, 32'(bus.cnt_r), 32'(r));
        chk({tag, "_cnt_g"}, 32'(bus.cnt_g), 32'(g));
        chk({tag, "_cnt_b"}, 32'(bus.cnt_b), 32'(b));
        chk({tag, "_color"}, 32'(bus.color), 32'(c));
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.vsync    = 1'b1;
        bus.px_valid = 1'b0;
        bus.px_addr  = '0;
        bus.px_data  = '0;
        bus.start    = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_color", 32'(bus.color), 32'd0);
        chk("rst_cnt_r", 32'(bus.cnt_r), 32'd0);
        chk("rst_cnt_g", 32'(bus.cnt_g), 32'd0);
        chk("rst_cnt_b", 32'(bus.cnt_b), 32'd0);
        rst = 1'b0;
        tick();

        // Full frame of pure red.
        arm();
        fstart();
        pix(8'hE0, 16);
        expect_result("all_red", 16, 0, 0, 1, 1'b0);
        bus.vsync = 1'b1;
        tick();

        // Green wins; 8'h92 is unclassified.
        arm();
        fstart();
        pix(8'h1C, 6);
        pix(8'h03, 5);
        pix(8'h92, 5);
        expect_result("green", 0, 6, 5, 2, 1'b0);
        bus.vsync = 1'b1;
        tick();

        // Red/green tie resolves to red.
        arm();
        fstart();
        pix(8'hE0, 5);
        pix(8'h1C, 5);
        pix(8'hFF, 6);
        expect_result("tie", 5, 5, 0, 1, 1'b0);
        bus.vsync = 1'b1;
        tick();

        // Winner below MIN_COUNT gives no colour.
        arm();
        fstart();
        pix(8'hE0, 3);
        pix(8'hFF, 13);
        expect_result("weak", 3, 0, 0, 0, 1'b0);
        bus.vsync = 1'b1;
        tick();

        // Short frame closed by VSYNC rising.
        arm();
        fstart();
        pix(8'hE0, 7);
        bus.vsync = 1'b1;
        tick();
        expect_result("short", 7, 0, 0, 1, 1'b0);
        tick();
        chk("short_single_done", 32'(bus.done), 32'd0);

        // ARM pixels excluded; start in ACCUM and DECIDE ignored.
        arm();
        pix(8'h1C, 4);
        chk("arm_hold_busy", 32'(bus.busy), 32'd1);
        fstart();
        pix(8'hE0, 4);
        bus.start    = 1'b1;
        bus.px_valid = 1'b1;
        bus.px_addr  = AW'(addr);
        bus.px_data  = 8'hE0;
        tick();
        addr++;
        bus.start    = 1'b0;
        bus.px_valid = 1'b0;
        chk("accum_start_busy", 32'(bus.busy), 32'd1);
        pix(8'h03, 11);
        expect_result("ignore", 5, 0, 11, 3, 1'b1);
        tick();
        chk("decide_start_ignored", 32'(bus.busy), 32'd0);
        bus.vsync = 1'b1;
        tick();

        // Reset mid-ACCUM aborts with no done pulse.
        arm();
        fstart();
        pix(8'hE0, 8);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_color", 32'(bus.color), 32'd0);
        chk("abort_cnt_b", 32'(bus.cnt_b), 32'd0);
        chk("abort_cnt_r", 32'(bus.cnt_r), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end
        bus.vsync = 1'b1;
        tick();
        arm();
        fstart();
        pix(8'h1C, 16);
        expect_result("after_abort", 0, 16, 0, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
